// File: rtl/rca18_pair_feeder_if.sv
// Bundled operand, adder and result signals of the ripple-carry pair feeder.
// slave: the feeder itself; master: the operand source, adder and result sink around it.
interface rca18_pair_feeder_if #(
    parameter int N = 18
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;
    logic           in_cin;
    logic           in_last;
    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic           add_cin;
    logic [N:0]     add_sum;
    logic           out_valid;
    logic           out_ready;
    logic [N:0]     out_sum;
    logic [15:0]    pair_cnt;

    modport slave (
        input  in_valid, in_data, in_cin, in_last, add_sum, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, pair_cnt
    );

    modport master (
        output in_valid, in_data, in_cin, in_last, add_sum, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, pair_cnt
    );
endinterface

// File: rtl/rca18_pair_feeder.sv
// Purpose: buffers operands, pairs them (A, B, cin) onto an external adder and captures its sum.
// Latency: out_valid 2+EVAL_CYCLES cycles after the A pop; one result per 3+EVAL_CYCLES cycles at best.
// Backpressure: result held in OUT until out_ready; FIFO keeps accepting until full (no pass-through).
// Option RCA_PAIR_FLUSH_EN: in_last on an A operand flushes it as A+0 without waiting for B.
module rca18_pair_feeder #(
    parameter int N           = 18,
    parameter int DEPTH       = 4,
    parameter int EVAL_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rca18_pair_feeder_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] EV_LOAD = 4'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_B, EVAL, OUT} state_t;

    logic [N-1:0]   mem_data [DEPTH];
    logic [DEPTH-1:0] mem_cin;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [N-1:0]   rd_data;
    logic           rd_cin;

    state_t         state;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           cin_r;
    logic [3:0]     ev_cnt;
    logic           out_valid_r;
    logic [N:0]     out_sum_r;
    logic [15:0]    pair_cnt_r;

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = !empty && ((state == IDLE) || (state == WAIT_B));
    assign rd_data      = mem_data[rd_ptr];
    assign rd_cin       = mem_cin[rd_ptr];

`ifdef RCA_PAIR_FLUSH_EN
    logic [DEPTH-1:0] mem_last;
    logic             rd_last;
    assign rd_last = mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_last[wr_ptr] <= bus.in_last;
        end
    end
`else
    logic unused_last;
    assign unused_last = bus.in_last;
`endif

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.in_data;
            mem_cin[wr_ptr]  <= bus.in_cin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            cin_r       <= 1'b0;
            ev_cnt      <= '0;
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            pair_cnt_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        op_a <= rd_data;
`ifdef RCA_PAIR_FLUSH_EN
                        if (rd_last) begin
                            op_b   <= '0;
                            cin_r  <= 1'b0;
                            ev_cnt <= EV_LOAD;
                            state  <= EVAL;
                        end else begin
                            state  <= WAIT_B;
                        end
`else
                        state <= WAIT_B;
`endif
                    end
                end
                WAIT_B: begin
                    if (!empty) begin
                        op_b   <= rd_data;
                        cin_r  <= rd_cin;
                        ev_cnt <= EV_LOAD;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    // The adder output is only trusted on the last cycle of the window.
                    if (ev_cnt == '0) begin
                        out_sum_r   <= bus.add_sum;
                        out_valid_r <= 1'b1;
                        state       <= OUT;
                    end else begin
                        ev_cnt <= ev_cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        pair_cnt_r  <= pair_cnt_r + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.add_a     = op_a;
    assign bus.add_b     = op_b;
    assign bus.add_cin   = cin_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.pair_cnt  = pair_cnt_r;

endmodule

// File: tb/tb_rca18_pair_feeder.sv
// Directed bench for rca18_pair_feeder: default instance plus an EVAL_CYCLES=3 instance,
// each fed by a behavioural ripple adder; flush expectations follow RCA_PAIR_FLUSH_EN.
module tb_rca18_pair_feeder;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst3 = 1'b0;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rca18_pair_feeder_if #(.N(18)) bi ();
    rca18_pair_feeder_if #(.N(18)) b3 ();

    assign bi.add_sum = {1'b0, bi.add_a} + {1'b0, bi.add_b} + {18'd0, bi.add_cin};
    assign b3.add_sum = {1'b0, b3.add_a} + {1'b0, b3.add_b} + {18'd0, b3.add_cin};

    rca18_pair_feeder #(.N(18), .DEPTH(4), .EVAL_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi.slave)
    );

    rca18_pair_feeder #(.N(18), .DEPTH(4), .EVAL_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (b3.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] d, input logic c, input logic l);
        int   n   = 0;
        logic acc = 1'b0;
        bi.in_valid = 1'b1;
        bi.in_data  = d;
        bi.in_cin   = c;
        bi.in_last  = l;
        while (!acc && n < 50) begin
            acc = bi.in_ready;
            step();
            n++;
        end
        bi.in_valid = 1'b0;
        bi.in_last  = 1'b0;
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (bi.out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("wait_valid", 32'(bi.out_valid), 32'd1);
    endtask

    task automatic take(input logic [18:0] exp, input string tag);
        wait_valid(20);
        check(tag, 32'(bi.out_sum), 32'(exp));
        bi.out_ready = 1'b1;
        step();
        bi.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bi.out_valid), 32'd0);
    endtask

    initial begin
        int bad;
        bi.in_valid = 1'b0; bi.in_data = '0; bi.in_cin = 1'b0; bi.in_last = 1'b0; bi.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_cin = 1'b0; b3.in_last = 1'b0; b3.out_ready = 1'b0;
        rst  = 1'b1;
        rst3 = 1'b1;
        #3;
        check("rst_in_ready",  32'(bi.in_ready),  32'd1);
        check("rst_add_a",     32'(bi.add_a),     32'd0);
        check("rst_add_b",     32'(bi.add_b),     32'd0);
        check("rst_add_cin",   32'(bi.add_cin),   32'd0);
        check("rst_out_valid", 32'(bi.out_valid), 32'd0);
        check("rst_out_sum",   32'(bi.out_sum),   32'd0);
        check("rst_pair_cnt",  32'(bi.pair_cnt),  32'd0);
        step();
        step();
        rst  = 1'b0;
        rst3 = 1'b0;
        step();

        // First pair: 0x3FFFF + 0x00001 + 1 = 0x40001, out_valid two edges after the B pop.
        push(18'h3FFFF, 1'b0, 1'b0);
        check("a_not_popped_yet", 32'(bi.add_a), 32'd0);
        push(18'h00001, 1'b1, 1'b0);
        check("a_popped", 32'(bi.add_a), 32'h3FFFF);
        check("lat_k1_valid", 32'(bi.out_valid), 32'd0);
        step();
        check("b_popped", 32'(bi.add_b), 32'h00001);
        check("b_cin", 32'(bi.add_cin), 32'd1);
        check("lat_k2_valid", 32'(bi.out_valid), 32'd0);
        step();
        check("lat_k3_valid", 32'(bi.out_valid), 32'd1);
        check("sum_first", 32'(bi.out_sum), 32'h40001);
        check("cnt_before_hs", 32'(bi.pair_cnt), 32'd0);
        bi.out_ready = 1'b1;
        step();
        bi.out_ready = 1'b0;
        check("first_drop", 32'(bi.out_valid), 32'd0);
        check("cnt_first", 32'(bi.pair_cnt), 32'd1);

        // Stall a result in OUT, then fill the FIFO behind it.
        push(18'd10, 1'b0, 1'b0);
        push(18'd20, 1'b0, 1'b0);
        wait_valid(10);
        push(18'd30, 1'b0, 1'b0);
        push(18'd40, 1'b0, 1'b0);
        push(18'd50, 1'b0, 1'b0);
        check("ready_at_3", 32'(bi.in_ready), 32'd1);
        push(18'd60, 1'b0, 1'b0);
        check("full_ready", 32'(bi.in_ready), 32'd0);
        bi.in_valid = 1'b1;
        bi.in_data  = 18'd70;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bi.out_sum !== 19'd30 || bi.add_a !== 18'd10 || bi.add_b !== 18'd20 ||
                bi.out_valid !== 1'b1 || bi.in_ready !== 1'b0) bad++;
        end
        bi.in_valid = 1'b0;
        check("stall_stable", 32'(bad), 32'd0);
        take(19'd30, "sum_10_20");
        check("cnt_once", 32'(bi.pair_cnt), 32'd2);
        push(18'd70, 1'b0, 1'b0);
        push(18'd80, 1'b0, 1'b0);
        take(19'd70, "sum_30_40");
        take(19'd110, "sum_50_60");
        take(19'd150, "sum_70_80");
        check("cnt_after_fill", 32'(bi.pair_cnt), 32'd5);

        // EVAL_CYCLES=3 instance: full latency, then reset in the second EVAL cycle.
        b3.in_valid = 1'b1; b3.in_data = 18'd5; b3.in_cin = 1'b0;
        step();
        b3.in_data = 18'd6; b3.in_cin = 1'b1;
        step();
        b3.in_valid = 1'b0;
        step();
        check("e3_add_a", 32'(b3.add_a), 32'd5);
        check("e3_add_b", 32'(b3.add_b), 32'd6);
        step();
        step();
        check("e3_not_yet", 32'(b3.out_valid), 32'd0);
        step();
        check("e3_valid", 32'(b3.out_valid), 32'd1);
        check("e3_sum", 32'(b3.out_sum), 32'd12);
        b3.out_ready = 1'b1;
        step();
        b3.out_ready = 1'b0;
        check("e3_cnt", 32'(b3.pair_cnt), 32'd1);

        b3.in_valid = 1'b1; b3.in_data = 18'd3; b3.in_cin = 1'b1;
        step();
        b3.in_data = 18'd4;
        step();
        b3.in_data = 18'd7;
        step();
        b3.in_data = 18'd8;
        step();
        b3.in_valid = 1'b0;
        #2;
        rst3 = 1'b1;
        #1;
        check("mid_rst_valid", 32'(b3.out_valid), 32'd0);
        check("mid_rst_add_a", 32'(b3.add_a), 32'd0);
        check("mid_rst_add_b", 32'(b3.add_b), 32'd0);
        check("mid_rst_cin", 32'(b3.add_cin), 32'd0);
        check("mid_rst_sum", 32'(b3.out_sum), 32'd0);
        check("mid_rst_cnt", 32'(b3.pair_cnt), 32'd0);
        check("mid_rst_ready", 32'(b3.in_ready), 32'd1);
        step();
        rst3 = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b3.out_valid !== 1'b0 || b3.add_a !== 18'd0) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);

        // Odd group 5, 7, 9 with last on the 9.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("flush_cnt_reset", 32'(bi.pair_cnt), 32'd0);
        push(18'd5, 1'b0, 1'b0);
        push(18'd7, 1'b0, 1'b0);
        push(18'd9, 1'b0, 1'b1);
        take(19'd12, "flush_pair");
`ifdef RCA_PAIR_FLUSH_EN
        take(19'd9, "flush_odd");
        check("flush_add_b", 32'(bi.add_b), 32'd0);
        check("flush_cnt", 32'(bi.pair_cnt), 32'd2);
`else
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bi.out_valid !== 1'b0) bad++;
        end
        check("park_no_result", 32'(bad), 32'd0);
        check("park_add_a", 32'(bi.add_a), 32'd9);
        check("park_cnt", 32'(bi.pair_cnt), 32'd1);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/rca18_pair_feeder.md
# rca18_pair_feeder

Operand-pairing front end for the clocked 18-bit AOI/OAI ripple-carry adder stage. It buffers a stream of 18-bit operands, forms (A, B, carry-in) pairs, and holds them stable on the adder inputs for the evaluation window. It then captures the 19-bit adder sum into a registered valid/ready output toward the next tree level. The adder itself sits outside this block: the feeder drives its inputs and samples its sum.

## Interface
- `N`, 18: operand width; the sum is N+1 bits.
- `DEPTH`, 4: input FIFO entries; must be a power of 2, at least 2.
- `EVAL_CYCLES`, 1: clock cycles operands are held on the adder before the sum is sampled; range 1–15.

- `clk`  in  1  single clock; all registers update on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  FIFO can accept an operand; equals !full.
- `in_data`  in  N  operand.
- `in_cin`  in  1  carry-in; used only when this operand becomes B.
- `in_last`  in  1  end-of-group marker; see Configuration.
- `add_a`  out  N  registered A operand to the adder.
- `add_b`  out  N  registered B operand to the adder.
- `add_cin`  out  1  registered carry-in to the adder.
- `add_sum`  in  N+1  adder result; `{cout, s}`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  N+1  captured result.
- `pair_cnt`  out  16  completed results; wraps from 0xFFFF to 0.

## Operation

**Input FIFO**
- A push occurs on `in_valid && in_ready`.
- A pushed entry is poppable from the next cycle onward.
- There is no pass-through: when full, `in_ready` is 0 even if a pop happens in the same cycle.
- Pointers wrap modulo `DEPTH`.
- A separate count register distinguishes full from empty.

**FSM states:** IDLE, WAIT_B, EVAL, OUT.

**IDLE**
- If the FIFO is non-empty, pop the entry: `op_a <= data` and go to WAIT_B.
- Otherwise stay in IDLE.

**WAIT_B**
- If the FIFO is non-empty, pop the entry: `op_b <= data`, `cin_r <= entry cin`, load `ev_cnt <= EVAL_CYCLES-1`, and go to EVAL.

**EVAL**
- If `ev_cnt == 0`, then `out_sum <= add_sum`, `out_valid <= 1`, and go to OUT.
- Otherwise decrement `ev_cnt`.

**OUT**
- On `out_valid && out_ready`: `out_valid <= 0`, `pair_cnt++`, and go to IDLE.
- Otherwise hold.

**Adder drive**
- `add_a`, `add_b` and `add_cin` are `op_a`, `op_b` and `cin_r` directly.
- They change only on pops, so they are stable for the whole EVAL window and while in OUT.
- The A operand's `cin` is discarded.

**Arithmetic:** none is performed in this block. `out_sum` is the 19-bit adder output captured unmodified.

## Timing
- **Reset values:** `in_ready=1`, `add_a=0`, `add_b=0`, `add_cin=0`, `out_valid=0`, `out_sum=0`, `pair_cnt=0`, FSM in IDLE, FIFO empty.
- **Reset mid-operation:** all outputs return asynchronously to the values above. The FIFO contents and any in-flight pair are discarded; there is no partial output.
- **Latency:**
  - If A is popped in cycle k and B is available, B is popped in cycle k+1.
  - EVAL occupies cycles k+2 through k+1+`EVAL_CYCLES`.
  - `out_valid` is first high in cycle k+2+`EVAL_CYCLES`; this is k+3 at the default.
- **Throughput:** at most one result per 3+`EVAL_CYCLES` cycles, because IDLE costs one cycle after each output handshake.
- **Output stability:** `out_sum` is stable while `out_valid=1 && !out_ready`.
- **Output stall:** while in OUT, the FIFO continues to accept pushes until full.
- **Sampling point:** `add_sum` is sampled only on the final EVAL cycle; its value at all other times is don't-care.

## Configuration
- **Macro:** `RCA_PAIR_FLUSH_EN`.
- **Defined:**
  - `in_last` is stored per FIFO entry.
  - When an A operand popped in IDLE has last=1, the block loads `op_b <= 0`, `cin_r <= 0` and `ev_cnt <= EVAL_CYCLES-1` in the same cycle and goes directly to EVAL, skipping WAIT_B.
  - An odd-length group therefore yields A+0.
  - last=1 on a B operand has no effect.
- **Undefined:**
  - `in_last` is ignored and not stored.
  - An unpaired A waits in WAIT_B indefinitely for the next operand.

## Test plan
- **Reset, then push pair:** reset, then push 0x3FFFF (cin x) followed by 0x00001 with cin=1. Required: `add_sum` sampled, `out_sum=0x40001`, `out_valid` high 3 cycles after the A pop, `pair_cnt=1` after the handshake.
- **FIFO full:** push 5 operands with `out_ready=0`. Required: `in_ready` falls after the 4th buffered entry, the 5th push is stalled, and no data is lost.
- **Backpressure:** hold `out_ready=0` for 10 cycles in OUT. Required: `out_sum` and `add_a`/`add_b` are unchanged; the result is accepted exactly once when `out_ready` rises.
- **Reset mid-EVAL:** with `EVAL_CYCLES=3`, assert `rst` during cycle 2 of EVAL. Required: `out_valid=0`, `add_*=0`, FIFO empty, and no result emitted.
- **Flush, macro on:** with `RCA_PAIR_FLUSH_EN` defined, push 3 operands 5, 7, 9 with last=1 on the 9. Required: results 12 and then 9, and `pair_cnt=2`.
- **Flush, macro off:** run the same stimulus without the macro. Required: result 12 only, with the FSM parked in WAIT_B.
